// File: rtl/cpu_pkg.sv
// Shared definitions for the branch-condition unit.
//   cond_t         : 3-bit condition mode taken from the IR condition field
//   COND_ZERO..LTU : mode encodings
//   con_state_t    : control FSM states of con_ff_cmp
//   cond_two_op()  : true for modes that compare opa against a second operand
package cpu_pkg;

  typedef logic [2:0] cond_t;

  localparam cond_t COND_ZERO    = 3'd0;
  localparam cond_t COND_NONZERO = 3'd1;
  localparam cond_t COND_NONNEG  = 3'd2;
  localparam cond_t COND_NEG     = 3'd3;
  localparam cond_t COND_EQ      = 3'd4;
  localparam cond_t COND_NE      = 3'd5;
  localparam cond_t COND_LT      = 3'd6;
  localparam cond_t COND_LTU     = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT_B = 2'd1,
    ST_EVAL   = 2'd2,
    ST_HOLD   = 2'd3
  } con_state_t;

  // Modes 4..7 need opb; the encoding puts them all in the upper half.
  function automatic logic cond_two_op(input cond_t c);
    return c[2];
  endfunction

endpackage

// File: rtl/con_cmp_core.sv
// Purely combinational condition evaluator.
//   opa, opb : operands (opb ignored by single-operand modes)
//   mode     : condition mode (cpu_pkg cond_t)
//   result   : 1 when the selected condition holds
module con_cmp_core
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  cond_t            mode,
  output logic             result
);

  logic [WIDTH:0] sub;
  logic           borrow;
  logic           lt_signed;

  // One zero-extended subtraction serves both ordered compares: the extra
  // top bit is the unsigned borrow, and for signed compares the difference
  // sign is only trusted when the operand signs agree (no overflow possible).
  always_comb begin
    sub       = {1'b0, opa} - {1'b0, opb};
    borrow    = sub[WIDTH];
    lt_signed = (opa[WIDTH-1] != opb[WIDTH-1]) ? opa[WIDTH-1] : sub[WIDTH-1];
  end

  always_comb begin
    result = 1'b0;
    case (mode)
      COND_ZERO:    result = (opa == '0);
      COND_NONZERO: result = (opa != '0);
      COND_NONNEG:  result = ~opa[WIDTH-1];
      COND_NEG:     result = opa[WIDTH-1];
      COND_EQ:      result = (opa == opb);
      COND_NE:      result = (opa != opb);
      COND_LT:      result = lt_signed;
      COND_LTU:     result = borrow;
      default:      result = 1'b0;
    endcase
  end

endmodule

// File: rtl/con_ff_cmp.sv
// Branch-condition unit: captures one or two operands from the shared bus,
// evaluates the condition selected by the IR field and holds the registered
// result until cleared or a new capture starts.
//   clock   : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : shared datapath bus (operand source)
//   ir      : instruction register; cond = ir[COND_LSB+2:COND_LSB]
//   con_in  : capture strobe
//   con_clr : abort / clear result, back to IDLE (wins over con_in)
//   con     : registered branch-taken result, meaningful while valid=1
//   valid   : result held
//   busy    : evaluation in progress (WAIT_B or EVAL)
module con_ff_cmp
  import cpu_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int IR_WIDTH = 32,
  parameter int COND_LSB = 19
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [WIDTH-1:0]    bus,
  input  logic [IR_WIDTH-1:0] ir,
  input  logic                con_in,
  input  logic                con_clr,
  output logic                con,
  output logic                valid,
  output logic                busy
);

  con_state_t       state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  cond_t            mode_q, mode_d;
  logic             con_q, con_d;
  logic             valid_q, valid_d;

  cond_t            cond;
  logic             result;
  logic             unused_ir;

  assign cond = ir[COND_LSB+2:COND_LSB];
  // The rest of the IR belongs to other consumers; fold it into a sink.
  assign unused_ir = ^ir;

  con_cmp_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .opa    (opa_q),
    .opb    (opb_q),
    .mode   (mode_q),
    .result (result)
  );

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    mode_d  = mode_q;
    con_d   = con_q;
    valid_d = valid_q;

    if (con_clr) begin
      state_d = ST_IDLE;
      con_d   = 1'b0;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        // HOLD behaves like IDLE on a new capture; the old result is dropped.
        ST_IDLE, ST_HOLD: begin
          if (con_in) begin
            opa_d   = bus;
            mode_d  = cond;
            con_d   = 1'b0;
            valid_d = 1'b0;
            state_d = cond_two_op(cond) ? ST_WAIT_B : ST_EVAL;
          end
        end
        ST_WAIT_B: begin
          if (con_in) begin
            opb_d   = bus;
            state_d = ST_EVAL;
          end
        end
        ST_EVAL: begin
          con_d   = result;
          valid_d = 1'b1;
          state_d = ST_HOLD;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      mode_q  <= COND_ZERO;
      con_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      mode_q  <= mode_d;
      con_q   <= con_d;
      valid_q <= valid_d;
    end
  end

  assign con   = con_q;
  assign valid = valid_q;
  assign busy  = (state_q == ST_WAIT_B) || (state_q == ST_EVAL);

endmodule

// File: tb/tb_con_ff_cmp.sv
// Bench for con_ff_cmp: a 32-bit instance (COND_LSB=19) and an 8-bit
// instance (COND_LSB=0) run every transaction in parallel against a
// width-generic reference model of the branch conditions.
module tb_con_ff_cmp;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        con_in;
  logic        con_clr;
  logic [31:0] bus;
  logic [7:0]  bus8;
  logic [31:0] ir32;
  logic [7:0]  ir8;

  logic con32, valid32, busy32;
  logic con8, valid8, busy8;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign bus8 = bus[7:0];

  con_ff_cmp #(
    .WIDTH    (32),
    .IR_WIDTH (32),
    .COND_LSB (19)
  ) dut32 (
    .clock   (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .ir      (ir32),
    .con_in  (con_in),
    .con_clr (con_clr),
    .con     (con32),
    .valid   (valid32),
    .busy    (busy32)
  );

  con_ff_cmp #(
    .WIDTH    (8),
    .IR_WIDTH (8),
    .COND_LSB (0)
  ) dut8 (
    .clock   (clk),
    .reset_n (reset_n),
    .bus     (bus8),
    .ir      (ir8),
    .con_in  (con_in),
    .con_clr (con_clr),
    .con     (con8),
    .valid   (valid8),
    .busy    (busy8)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Condition rules evaluated on w-bit operands with plain integer arithmetic.
  function automatic bit ref_cond(input int w, input int mode,
                                  input longint unsigned a_in, input longint unsigned b_in);
    longint unsigned mask, a, b;
    longint          sa, sb;
    bit              neg_a, neg_b;
    mask  = (64'd1 << w) - 64'd1;
    a     = a_in & mask;
    b     = b_in & mask;
    neg_a = ((a >> (w - 1)) & 64'd1) != 0;
    neg_b = ((b >> (w - 1)) & 64'd1) != 0;
    sa    = neg_a ? longint'(a) - longint'(64'd1 << w) : longint'(a);
    sb    = neg_b ? longint'(b) - longint'(64'd1 << w) : longint'(b);
    case (mode)
      0:       return a == 0;
      1:       return a != 0;
      2:       return !neg_a;
      3:       return neg_a;
      4:       return a == b;
      5:       return a != b;
      6:       return sa < sb;
      default: return a < b;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cond(input int cond);
    ir32        = $urandom;
    ir32[21:19] = 3'(cond);
    ir8         = 8'($urandom);
    ir8[2:0]    = 3'(cond);
  endtask

  task automatic expect_status(input string tag, input bit busy_e, input bit valid_e);
    check_eq({tag, "_busy32"},  32'(busy32),  32'(busy_e));
    check_eq({tag, "_valid32"}, 32'(valid32), 32'(valid_e));
    check_eq({tag, "_busy8"},   32'(busy8),   32'(busy_e));
    check_eq({tag, "_valid8"},  32'(valid8),  32'(valid_e));
  endtask

  // One full branch evaluation. gap = idle cycles in WAIT_B; poke_eval drives
  // a stray con_in during EVAL, which must be ignored.
  task automatic txn(input int cond, input logic [31:0] a, input logic [31:0] b,
                     input int gap, input bit poke_eval);
    bit exp32, exp8;
    exp32 = ref_cond(32, cond, 64'(a), 64'(b));
    exp8  = ref_cond(8,  cond, 64'(a), 64'(b));
    set_cond(cond);
    bus    = a;
    con_in = 1'b1;
    tick();
    con_in = 1'b0;
    ir32   = $urandom;
    ir8    = 8'($urandom);
    bus    = $urandom;
    expect_status("cap", 1'b1, 1'b0);
    if (cond >= 4) begin
      for (int g = 0; g < gap; g++) begin
        bus  = $urandom;
        ir32 = $urandom;
        ir8  = 8'($urandom);
        tick();
        expect_status("waitb", 1'b1, 1'b0);
      end
      bus    = b;
      con_in = 1'b1;
      tick();
      con_in = 1'b0;
      bus    = $urandom;
      expect_status("eval", 1'b1, 1'b0);
    end
    if (poke_eval) begin
      con_in = 1'b1;
      bus    = $urandom;
    end
    tick();
    con_in = 1'b0;
    expect_status("hold", 1'b0, 1'b1);
    check_eq("con32", 32'(con32), 32'(exp32));
    check_eq("con8",  32'(con8),  32'(exp8));
    $display("txn cond=%0d a=%08h b=%08h gap=%0d poke=%0b con32=%0b exp=%0b con8=%0b exp=%0b",
             cond, a, b, gap, poke_eval, con32, exp32, con8, exp8);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      4:       return 32'($urandom_range(0, 255));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset_n = 1'b0;
    con_in  = 1'b0;
    con_clr = 1'b0;
    bus     = '0;
    ir32    = '0;
    ir8     = '0;
    #2;
    expect_status("rst", 1'b0, 1'b0);
    check_eq("rst_con32", 32'(con32), 32'd0);
    check_eq("rst_con8",  32'(con8),  32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    expect_status("idle", 1'b0, 1'b0);

    // Zero tests over all bits.
    txn(0, 32'h4000_0000, 32'h0, 0, 1'b0);
    txn(0, 32'h0000_0000, 32'h0, 0, 1'b0);
    txn(1, 32'h8000_0000, 32'h0, 0, 1'b0);
    // Signed vs unsigned ordering.
    txn(6, 32'hFFFF_FFFF, 32'h0000_0001, 0, 1'b0);
    txn(7, 32'hFFFF_FFFF, 32'h0000_0001, 0, 1'b0);
    txn(6, 32'h7FFF_FFFF, 32'h8000_0000, 0, 1'b0);
    // EQ/NE with a long WAIT_B gap; stray con_in in EVAL.
    txn(4, 32'h0000_1234, 32'h0000_1234, 5, 1'b0);
    txn(5, 32'h0000_1234, 32'h0000_1234, 5, 1'b1);
    // Narrow-width cases.
    txn(3, 32'h0000_0080, 32'h0, 0, 1'b0);
    txn(7, 32'h0000_0000, 32'h0000_00FF, 0, 1'b0);

    // Asynchronous reset while holding con=1, between clock edges.
    txn(0, 32'h0, 32'h0, 0, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    expect_status("arst", 1'b0, 1'b0);
    check_eq("arst_con32", 32'(con32), 32'd0);
    check_eq("arst_con8",  32'(con8),  32'd0);
    #1;
    reset_n = 1'b1;
    tick();
    expect_status("arst_idle", 1'b0, 1'b0);

    // con_clr beats a simultaneous con_in in WAIT_B.
    set_cond(4);
    bus    = 32'h55;
    con_in = 1'b1;
    tick();
    expect_status("clr_pre", 1'b1, 1'b0);
    con_clr = 1'b1;
    bus     = 32'hAA;
    tick();
    con_clr = 1'b0;
    con_in  = 1'b0;
    expect_status("clr", 1'b0, 1'b0);
    tick();
    expect_status("clr_stay", 1'b0, 1'b0);
    $display("txn clr_in_waitb busy32=%0b valid32=%0b", busy32, valid32);

    // con_clr in HOLD drops the result.
    txn(1, 32'h1, 32'h0, 0, 1'b0);
    con_clr = 1'b1;
    tick();
    con_clr = 1'b0;
    expect_status("clr_hold", 1'b0, 1'b0);
    check_eq("clr_hold_con32", 32'(con32), 32'd0);
    $display("txn clr_in_hold valid32=%0b con32=%0b", valid32, con32);

    // Randomised back-to-back transactions (each restarts from HOLD).
    for (int i = 0; i < 40; i++) begin
      int          c;
      logic [31:0] a, b;
      c = int'($urandom_range(0, 7));
      a = pick();
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = a ^ (32'd1 << $urandom_range(0, 31));
        default: b = pick();
      endcase
      txn(c, a, b, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/con_ff_cmp.md
Name: con_ff_cmp

Overview:
Parametrised branch-condition unit for the RISC datapath, replacing the single-operand CON flip-flop.
- Captures one or two operands from the shared bus under control-unit strobes.
- Evaluates one of eight condition modes selected by an IR field, and holds the registered result on con until the control unit clears it.
- Feeds the PC-load decision for conditional branches.

Parameters:
WIDTH, 32, bus/operand width in bits (>=2)
IR_WIDTH, 32, instruction register width
COND_LSB, 19, bit position of the 3-bit condition field in ir (COND_LSB+2 < IR_WIDTH)

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
bus  in  WIDTH  shared datapath bus; operand source
ir  in  IR_WIDTH  instruction register; cond = ir[COND_LSB+2:COND_LSB]
con_in  in  1  capture strobe: latch bus as next operand
con_clr  in  1  discard result/partial capture, return to IDLE
con  out  1  registered branch-taken result, valid only while valid=1
valid  out  1  result held
busy  out  1  evaluation in progress (WAIT_B or EVAL)

Behaviour:
- Reset (async, reset_n=0): state=IDLE, opa=0, opb=0, mode=0, con=0, valid=0, busy=0. Outputs must go low without waiting for a clock edge.
- Modes, latched from the cond field at the first capture and not re-read afterwards:
  - 0 ZERO: opa==0
  - 1 NONZERO: opa!=0
  - 2 NONNEG: opa[WIDTH-1]==0
  - 3 NEG: opa[WIDTH-1]==1
  - 4 EQ: opa==opb
  - 5 NE: opa!=opb
  - 6 LT: opa<opb, signed
  - 7 LTU: opa<opb, unsigned
- Zero tests cover all WIDTH bits.
- LT/LTU use one WIDTH+1-bit subtraction:
  - LTU = borrow.
  - LT = (sign_a != sign_b) ? sign_a : diff[WIDTH-1].
- FSM states: IDLE, WAIT_B, EVAL, HOLD.
  - IDLE: on con_in, opa<=bus and mode<=cond. Next state is EVAL if cond<4, else WAIT_B.
  - WAIT_B: on con_in, opb<=bus, go to EVAL. Otherwise stay; no timeout.
  - EVAL: compute result; at the edge, con<=result, valid<=1, go to HOLD.
  - HOLD: con/valid stable. A con_in here starts a new capture exactly as in IDLE; con and valid drop to 0 at that edge.
- con_clr: from any state, go to IDLE at the next edge with con=0, valid=0. It has priority over a simultaneous con_in, which is ignored.
- Latency: con valid 2 edges after a single-operand capture, and 2 edges after the opb capture for two-operand modes.
- busy=1 exactly in WAIT_B and EVAL.
- con and valid are registered, with no combinational path from bus/ir.
- bus and ir changes outside capture edges have no effect. Changing ir mid-operation does not alter the latched mode.
- con_in in EVAL is ignored.

Decomposition:
- Shared package (cpu_pkg): condition mode constants COND_ZERO..COND_LTU, 3-bit cond_t typedef, FSM state enum.
- One natural sub-module: con_cmp_core, purely combinational (opa, opb, mode -> result), reusable by a future ALU flag path. The FSM and registers stay in con_ff_cmp.

Test Plan:
- Reset mid-HOLD with con=1: drive reset_n=0 between edges. con=0, valid=0 immediately; state IDLE, no clock needed.
- ZERO/NONZERO all-bit check: cond=0, bus=0x4000_0000 -> con=0. cond=0, bus=0 -> con=1. cond=1, bus=0x8000_0000 -> con=1. Each valid 2 edges after con_in.
- Signed vs unsigned: cond=6, opa=0xFFFF_FFFF, opb=0x0000_0001 -> con=1 (-1<1). cond=7 with same operands -> con=0. cond=6, opa=0x7FFF_FFFF, opb=0x8000_0000 -> con=0.
- EQ/NE with gap: cond=4, opa=0x1234, idle 5 cycles in WAIT_B with busy=1 and bus changing, then opb=0x1234 -> con=1. Repeat with cond=5 -> con=0.
- Priority and abort: con_clr with con_in together in WAIT_B -> IDLE, opb unchanged, valid=0. con_in in HOLD -> valid drops next edge, new result 2 edges later.
- Parameter sweep: WIDTH=8, COND_LSB=0. NEG with bus=0x80 -> con=1. LTU with 0x00 vs 0xFF -> con=1.
